// File: rtl/fre_meas_sched_if.sv
// Result stream of the frequency measurement scheduler.
// Handshake: the producer raises res_valid with res_ch/res_M/res_N/res_timeout
// stable; the payload is consumed, and may only change, after a rising clock
// edge at which res_valid && res_ready are both high.
interface fre_meas_sched_if #(
   parameter int NCH = 4
);
   localparam int CHW = $clog2(NCH);

   logic           res_valid;
   logic           res_ready;
   logic [CHW-1:0] res_ch;
   logic [31:0]    res_M;
   logic [31:0]    res_N;
   logic           res_timeout;

   modport master (
      output res_valid,
      input  res_ready,
      output res_ch,
      output res_M,
      output res_N,
      output res_timeout
   );

   modport slave (
      input  res_valid,
      output res_ready,
      input  res_ch,
      input  res_M,
      input  res_N,
      input  res_timeout
   );
endinterface

// File: rtl/fre_meas_sched.sv
// Multi-channel equal-precision (reciprocal) frequency measurement scheduler.
// One shared counting engine is time-multiplexed over the enabled channels,
// lowest index first; each channel yields one (ch, M, N, timeout) result.
module fre_meas_sched #(
   parameter int          NCH            = 4,
   parameter int unsigned GATE_CYCLES    = 100_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
   input  logic              clk_100M,
   input  logic              rst_n,
   input  logic [NCH-1:0]    sig,
   input  logic [NCH-1:0]    ch_en,
   input  logic              start,
   output logic              busy,
   output logic              gate,
   output logic [2:0]        state_dbg,
   fre_meas_sched_if.master  res
);
   localparam int CHW = $clog2(NCH);

   // Elaboration-time parameter sanity: M must never wrap within a gate plus
   // the longest allowed wait for the closing edge.
   if (NCH < 2 || NCH > 8) begin : g_bad_nch
      $error("fre_meas_sched: NCH must be in 2..8");
   end
   if (GATE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_zero
      $error("fre_meas_sched: GATE_CYCLES and TIMEOUT_CYCLES must be nonzero");
   end
   if (64'(GATE_CYCLES) + 64'(TIMEOUT_CYCLES) >= 64'h1_0000_0000) begin : g_bad_range
      $error("fre_meas_sched: GATE_CYCLES + TIMEOUT_CYCLES must be below 2^32");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_ARM    = 3'd2,
      S_COUNT  = 3'd3,
      S_CLOSE  = 3'd4,
      S_OUTPUT = 3'd5
   } state_t;

   state_t         state_q, state_nx;
   logic [NCH-1:0] sync1, sync2, sync3, edge_q;
   logic [NCH-1:0] mask_q;
   logic [CHW-1:0] ch_q;
   logic [CHW-1:0] sel_idx;
   logic           sel_found;
   logic           sel_edge;
   logic [31:0]    m_cnt, n_cnt, t_cnt;
   logic [31:0]    res_m_q, res_n_q;
   logic           res_to_q;
   logic           t_hit, g_done, accept;

   // Two-flop synchronizer, delayed copy, registered rising-edge pulse; the
   // fixed latency is the same at gate open and close so it cancels in M.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         sync3  <= '0;
         edge_q <= '0;
      end else begin
         sync1  <= sig;
         sync2  <= sync1;
         sync3  <= sync2;
         edge_q <= sync2 & ~sync3;
      end
   end

   // Lowest remaining channel of the latched mask; served channels are
   // cleared from the mask, which gives the ascending scan order.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = CHW'(i);
         end
      end
   end

   assign sel_edge  = edge_q[ch_q];
   // t_cnt holds the number of completed wait cycles, so this is the last one.
   assign t_hit     = (t_cnt == 32'(TIMEOUT_CYCLES - 1));
   // In COUNT, m_cnt doubles as the gate counter (both start at 0 on opening).
   assign g_done    = (m_cnt == 32'(GATE_CYCLES - 1));
   assign accept    = start && (ch_en != '0);
   assign state_dbg = state_q;

   // State register.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nx;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nx      = state_q;
      busy          = (state_q != S_IDLE);
      gate          = (state_q == S_COUNT) || (state_q == S_CLOSE);
      res.res_valid = (state_q == S_OUTPUT);
      case (state_q)
         S_IDLE:   if (accept) state_nx = S_SELECT;
         S_SELECT: state_nx = sel_found ? S_ARM : S_IDLE;
         S_ARM: begin
            if (sel_edge)   state_nx = S_COUNT;
            else if (t_hit) state_nx = S_OUTPUT;
         end
         S_COUNT:  if (g_done) state_nx = S_CLOSE;
         S_CLOSE:  if (sel_edge || t_hit) state_nx = S_OUTPUT;
         S_OUTPUT: if (res.res_ready) state_nx = S_SELECT;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Counting datapath and result registers.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         mask_q   <= '0;
         ch_q     <= '0;
         m_cnt    <= '0;
         n_cnt    <= '0;
         t_cnt    <= '0;
         res_m_q  <= '0;
         res_n_q  <= '0;
         res_to_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) mask_q <= ch_en;
            end
            S_SELECT: begin
               t_cnt <= '0;
               if (sel_found) ch_q <= sel_idx;
            end
            S_ARM: begin
               if (sel_edge) begin
                  m_cnt <= '0;
                  n_cnt <= '0;
               end else begin
                  t_cnt <= t_cnt + 32'd1;
                  if (t_hit) begin
                     res_m_q  <= '0;
                     res_n_q  <= '0;
                     res_to_q <= 1'b1;
                  end
               end
            end
            S_COUNT: begin
               m_cnt <= m_cnt + 32'd1;
               // An edge on the final gate cycle is still inside the gate.
               if (sel_edge) n_cnt <= n_cnt + 32'd1;
               if (g_done)   t_cnt <= '0;
            end
            S_CLOSE: begin
               m_cnt <= m_cnt + 32'd1;
               if (sel_edge) begin
                  res_m_q  <= m_cnt + 32'd1;
                  res_n_q  <= n_cnt + 32'd1;
                  res_to_q <= 1'b0;
               end else begin
                  t_cnt <= t_cnt + 32'd1;
                  if (t_hit) begin
                     res_m_q  <= '0;
                     res_n_q  <= '0;
                     res_to_q <= 1'b1;
                  end
               end
            end
            S_OUTPUT: begin
               if (res.res_ready) mask_q[ch_q] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign res.res_ch      = ch_q;
   assign res.res_M       = res_m_q;
   assign res.res_N       = res_n_q;
   assign res.res_timeout = res_to_q;
endmodule

// File: tb/tb_fre_meas_sched.sv
// Bench for fre_meas_sched: periodic square-wave sources, a reference model
// from the reciprocal-counting rules, and a directed sequence of scans.
module tb_fre_meas_sched;
   localparam int          NCH   = 4;
   localparam int unsigned GATE  = 1000;
   localparam int unsigned TMO   = 5000;
   localparam int          CHW   = $clog2(NCH);
   localparam int          RW    = CHW + 65;
   localparam int          LIMIT = GATE + 2 * TMO + 200;

   logic           clk_100M;
   logic           rst_n;
   logic [NCH-1:0] sig;
   logic [NCH-1:0] ch_en;
   logic           start;
   logic           busy;
   logic           gate;
   logic [2:0]     state_dbg;
   logic [RW-1:0]  res_pk;

   int total;
   int bad;
   logic [RW-1:0] exp_q[$];
   int unsigned   per[NCH];
   int unsigned   pcnt[NCH];

   fre_meas_sched_if #(.NCH(NCH)) res_if ();

   fre_meas_sched #(
      .NCH(NCH),
      .GATE_CYCLES(GATE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_100M(clk_100M),
      .rst_n(rst_n),
      .sig(sig),
      .ch_en(ch_en),
      .start(start),
      .busy(busy),
      .gate(gate),
      .state_dbg(state_dbg),
      .res(res_if)
   );

   assign res_pk = {res_if.res_ch, res_if.res_M, res_if.res_N, res_if.res_timeout};

   // Clock.
   initial begin
      clk_100M = 1'b0;
      forever #5 clk_100M = ~clk_100M;
   end

   // Signal sources: period per[i] clocks (rising edge on wrap), 0 = held low.
   initial begin
      sig = '0;
      for (int i = 0; i < NCH; i++) pcnt[i] = 0;
      forever begin
         @(negedge clk_100M);
         for (int i = 0; i < NCH; i++) begin
            if (per[i] == 0) begin
               sig[i] = 1'b0;
            end else begin
               pcnt[i] = (pcnt[i] + 1 >= per[i]) ? 0 : pcnt[i] + 1;
               sig[i]  = (pcnt[i] < per[i] / 2);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_100M);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Reference: the gate opens on an edge, lasts GATE clocks, and closes on
   // the first edge strictly after it; with period p that is edge number
   // floor(GATE/p)+1, at k*p clocks. No edge at all gives a timeout result.
   function automatic logic [RW-1:0] model(input int ch);
      int unsigned k;
      if (per[ch] == 0) return {CHW'(ch), 32'd0, 32'd0, 1'b1};
      k = GATE / per[ch] + 1;
      return {CHW'(ch), 32'(k * per[ch]), 32'(k), 1'b0};
   endfunction

   // One complete scan: start, collect and check every result, then check
   // that busy drops and nothing else arrives.
   task automatic run_scan(input logic [NCH-1:0] mask, input int stall_first, input bit poke);
      logic [RW-1:0] e;
      logic [RW-1:0] held;
      int            w;
      bit            first;
      first = 1'b1;
      repeat (130) tick();
      for (int c = 0; c < NCH; c++) if (mask[c]) exp_q.push_back(model(c));
      ch_en = mask;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_rise", 128'(busy), 128'(1'b1));
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         w = 0;
         while (!res_if.res_valid && w < LIMIT) begin
            if (poke && (w % 500) == 3) begin
               ch_en = '1;
               start = 1'b1;
            end
            tick();
            w++;
            start = 1'b0;
            ch_en = mask;
         end
         check("valid_wait", 128'(res_if.res_valid), 128'(1'b1));
         if (!res_if.res_valid) begin
            exp_q.delete();
            break;
         end
         check("result", 128'(res_pk), 128'(e));
         if (e[0]) check("timeout_latency", 128'(w), 128'(TMO + 1));
         if (first && stall_first > 0) begin
            held = res_pk;
            for (int s = 0; s < stall_first; s++) begin
               tick();
               check("stall_hold", 128'({res_if.res_valid, gate, busy, res_pk}),
                     128'({1'b1, 1'b0, 1'b1, held}));
            end
         end
         first = 1'b0;
         res_if.res_ready = 1'b1;
         tick();
         res_if.res_ready = 1'b0;
         check("valid_drop", 128'(res_if.res_valid), 128'(1'b0));
      end
      tick();
      check("busy_fall", 128'(busy), 128'(1'b0));
      repeat (10) tick();
      check("no_extra", 128'({busy, res_if.res_valid}), 128'(2'b00));
   endtask

   // Directed sequence.
   initial begin
      int            w;
      logic [NCH-1:0] m;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      ch_en = '0;
      res_if.res_ready = 1'b0;
      for (int i = 0; i < NCH; i++) per[i] = 0;

      repeat (5) tick();
      check("reset_outputs", 128'({busy, gate, res_if.res_valid, res_pk}), 128'(0));
      rst_n = 1'b1;
      tick();
      check("post_reset", 128'({busy, gate, res_if.res_valid, res_pk}), 128'(0));

      // start with an empty mask is ignored
      ch_en = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("empty_mask_busy", 128'(busy), 128'(1'b0));
      repeat (20) tick();
      check("empty_mask_idle", 128'({busy, res_if.res_valid}), 128'(2'b00));

      // single channel, period 10: edge on the last gate cycle stays inside
      per[0] = 10;
      run_scan(4'b0001, 0, 1'b0);

      // channel 1, period 7, with start pulses while busy
      per[1] = 7;
      run_scan(4'b0010, 0, 1'b1);

      // ch0 measured, ch2 held low times out, first result stalled 50 cycles
      per[2] = 0;
      run_scan(4'b0101, 50, 1'b0);

      // reset in the middle of a gate
      ch_en = 4'b0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (!gate && w < LIMIT) begin
         tick();
         w++;
      end
      check("gate_open", 128'(gate), 128'(1'b1));
      repeat (300) tick();
      #3 rst_n = 1'b0;
      #1 check("async_reset", 128'({busy, gate, res_if.res_valid, res_pk}), 128'(0));
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("reset_release", 128'({busy, gate, res_if.res_valid, res_pk}), 128'(0));
      run_scan(4'b0001, 0, 1'b0);

      // randomized periods, masks, consumer stalls, at most one dead channel
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < NCH; c++) per[c] = $urandom_range(60, 4);
         if ($urandom_range(1, 0) == 1) per[$urandom_range(NCH - 1, 0)] = 0;
         m = NCH'($urandom_range((1 << NCH) - 1, 1));
         run_scan(m, $urandom_range(5, 0), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
